multicycle_main_controller: RTL and testbench

- Multi-cycle MIPS main control FSM; sequences one shared ALU, the register file and a unified instruction/data memory across FETCH/DECODE/EXECUTE/MEM/WB steps.
- Drives the 2-bit ALUOp into the existing ALU control decoder, which still maps func to the 3-bit ALUControl.
- Adds a memory ready handshake and a bus-timeout watchdog so a slow memory stalls the sequence instead of corrupting it.

---
 rtl/multicycle_main_controller_pkg.sv | 51 +++++
 rtl/multicycle_main_controller_if.sv | 34 +++
 rtl/multicycle_main_controller_mem_wait_watchdog.sv | 37 +++
 rtl/multicycle_main_controller.sv | 136 +++++++++++++
 tb/tb_multicycle_main_controller.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_main_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALUOp, mux selects, FSM states.
// Latency: none (constants and a pure helper function only).
// Backpressure: none.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_REG = 1'b1;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_FETCH    = 4'd1;
    localparam state_t S_DECODE   = 4'd2;
    localparam state_t S_MEMADR   = 4'd3;
    localparam state_t S_MEMREAD  = 4'd4;
    localparam state_t S_MEMWB    = 4'd5;
    localparam state_t S_MEMWRITE = 4'd6;
    localparam state_t S_EXEC     = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_ADDIEX   = 4'd10;
    localparam state_t S_ADDIWB   = 4'd11;
    localparam state_t S_JUMP     = 4'd12;
    localparam state_t S_HALT     = 4'd13;

    // States that hold a memory strobe and wait for mem_ready.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/multicycle_main_controller_if.sv
// Controller <-> datapath/memory control bundle; master is the controller, slave the datapath.
// Latency: none (wiring only).
// Backpressure: mem_ready from the memory side stalls the controller.
interface multicycle_main_controller_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic       bus_error;

    modport master (
        input  op, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_rd, mem_wr,
               ir_write, reg_dst, mem_to_reg, reg_write, illegal_op, bus_error
    );

    modport slave (
        output op, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_rd, mem_wr,
               ir_write, reg_dst, mem_to_reg, reg_write, illegal_op, bus_error
    );
endinterface

// File: rtl/multicycle_main_controller_mem_wait_watchdog.sv
// Counts mem_ready stall cycles in a memory state and latches a sticky bus_error on expiry.
// Latency: timeout is combinational from wait_cnt; bus_error registers one edge later.
// Backpressure: none; TIMEOUT_CYCLES=0 disables expiry.
module mem_wait_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_wait,
    input  logic enter,
    input  logic mem_ready,
    output logic timeout,
    output logic bus_error
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] wait_cnt;

    // A same-cycle mem_ready beats expiry, so it takes part in the compare.
    assign timeout = (TIMEOUT_CYCLES != 0) && in_wait && !mem_ready && (wait_cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            bus_error <= 1'b0;
        end else begin
            if (timeout)
                bus_error <= 1'b1;
            if (enter)
                wait_cnt <= '0;
            else if (in_wait && !mem_ready && (wait_cnt != '1))
                wait_cnt <= wait_cnt + ONE;
        end
    end
endmodule

// File: rtl/multicycle_main_controller.sv
// Multicycle MIPS main control FSM driving ALU, register file and unified memory selects.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles, plus one per mem_ready stall cycle.
// Backpressure: mem_ready low holds FETCH/MEMREAD/MEMWRITE; watchdog expiry parks in HALT.
module multicycle_main_controller
    import mips_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    multicycle_main_controller_if.master  bus
);
    state_t state, state_nxt;
    logic   timeout, bus_error, pc_write, branch;

    mem_wait_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_wait  (is_wait_state(state)),
        .enter    (is_wait_state(state_nxt) && (state_nxt != state)),
        .mem_ready(bus.mem_ready),
        .timeout  (timeout),
        .bus_error(bus_error)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     state_nxt = S_FETCH;
            S_FETCH:    if (bus.mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_nxt = S_MEMWB;
            S_MEMWRITE: if (bus.mem_ready) state_nxt = S_FETCH;
            S_EXEC:     state_nxt = S_ALUWB;
            S_ADDIEX:   state_nxt = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                        state_nxt = S_FETCH;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_IDLE;
        endcase
        if (timeout)
            state_nxt = S_HALT;
    end

    always_comb begin
        bus.alu_op     = ALUOP_ADD;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_REG;
        bus.pc_src     = PCSRC_ALU;
        bus.iord       = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.illegal_op = 1'b0;
        pc_write       = 1'b0;
        branch         = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_rd    = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                pc_write      = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b = SRCB_IMM_SL2;
                case (bus.op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ;
                    default: bus.illegal_op = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                bus.alu_src_a = SRCA_REG;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                bus.mem_rd = 1'b1;
                bus.iord   = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                bus.mem_wr = 1'b1;
                bus.iord   = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = SRCA_REG;
                bus.alu_op    = ALUOP_FUNC;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = SRCA_REG;
                bus.alu_op    = ALUOP_SUB;
                bus.pc_src    = PCSRC_ALUOUT;
                branch        = 1'b1;
            end
            S_ADDIWB:   bus.reg_write = 1'b1;
            S_JUMP: begin
                bus.pc_src = PCSRC_JUMP;
                pc_write   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pc_en     = pc_write | (branch & bus.zero);
    assign bus.bus_error = bus_error;
endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed bench for multicycle_main_controller: per-instruction output sequences, stalls, watchdog.
// A second instance with a short timeout exercises expiry and the mem_ready-wins boundary.
module tb_multicycle_main_controller;
    logic clk;
    logic rst_n;
    logic rst_wd_n;
    int   checks = 0;
    int   errors = 0;

    multicycle_main_controller_if ifc ();
    multicycle_main_controller_if ifc_wd ();

    multicycle_main_controller dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    multicycle_main_controller #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (3)
    ) dut_wd (
        .clk  (clk),
        .rst_n(rst_wd_n),
        .bus  (ifc_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {alu_op, src_a, src_b, pc_src, pc_en, iord, mem_rd, mem_wr,
    //               ir_write, reg_dst, mem_to_reg, reg_write, illegal_op, bus_error}
    logic [16:0] obs, obs_wd;
    assign obs = {ifc.alu_op, ifc.alu_src_a, ifc.alu_src_b, ifc.pc_src, ifc.pc_en, ifc.iord,
                  ifc.mem_rd, ifc.mem_wr, ifc.ir_write, ifc.reg_dst, ifc.mem_to_reg,
                  ifc.reg_write, ifc.illegal_op, ifc.bus_error};
    assign obs_wd = {ifc_wd.alu_op, ifc_wd.alu_src_a, ifc_wd.alu_src_b, ifc_wd.pc_src,
                     ifc_wd.pc_en, ifc_wd.iord, ifc_wd.mem_rd, ifc_wd.mem_wr, ifc_wd.ir_write,
                     ifc_wd.reg_dst, ifc_wd.mem_to_reg, ifc_wd.reg_write, ifc_wd.illegal_op,
                     ifc_wd.bus_error};

    localparam int T_IDLE = 0, T_FETCH = 1, T_DECODE = 2, T_DEC_ILL = 3, T_MEMADR = 4,
                   T_MEMREAD = 5, T_MEMWB = 6, T_MEMWRITE = 7, T_EXEC = 8, T_ALUWB = 9,
                   T_BRANCH = 10, T_ADDIEX = 11, T_ADDIWB = 12, T_JUMP = 13, T_HALT = 14;

    // Expected control word per state, written out from the state table.
    function automatic logic [16:0] exp_pat(input int s, input logic mr, input logic z);
        logic [1:0] aop, srcb, pcs;
        logic sa, pce, io, rd, wr, irw, rdst, m2r, rw, ill, be;
        {aop, srcb, pcs} = '0;
        {sa, pce, io, rd, wr, irw, rdst, m2r, rw, ill, be} = '0;
        case (s)
            T_FETCH:    begin rd = 1; srcb = 2'b01; irw = mr; pce = mr; end
            T_DECODE:   srcb = 2'b11;
            T_DEC_ILL:  begin srcb = 2'b11; ill = 1; end
            T_MEMADR,
            T_ADDIEX:   begin sa = 1; srcb = 2'b10; end
            T_MEMREAD:  begin rd = 1; io = 1; end
            T_MEMWB:    begin rw = 1; m2r = 1; end
            T_MEMWRITE: begin wr = 1; io = 1; end
            T_EXEC:     begin sa = 1; aop = 2'b10; end
            T_ALUWB:    begin rw = 1; rdst = 1; end
            T_BRANCH:   begin sa = 1; aop = 2'b01; pcs = 2'b01; pce = z; end
            T_ADDIWB:   rw = 1;
            T_JUMP:     begin pcs = 2'b10; pce = 1; end
            T_HALT:     be = 1;
            default: ;
        endcase
        return {aop, sa, srcb, pcs, pce, io, rd, wr, irw, rdst, m2r, rw, ill, be};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.op = 6'b100011; ifc.zero = 1'b0; ifc.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 17'h0) begin
            errors++; $display("FAIL reset_hold: got %h expected %h", obs, 17'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== exp_pat(T_IDLE, 1'b1, 1'b0)) begin
            errors++; $display("FAIL reset_idle: got %h expected %h", obs, 17'h0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        int seq[5] = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB};
        ifc.op = 6'b100011; ifc.mem_ready = 1'b1; ifc.zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_pat(seq[i], 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL lw_cycle%0d: got %h expected %h", i, obs, exp_pat(seq[i], 1'b1, 1'b0));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        int seq[4] = '{T_FETCH, T_DECODE, T_EXEC, T_ALUWB};
        ifc.op = 6'b000000; ifc.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_pat(seq[i], 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL rtype_cycle%0d: got %h expected %h", i, obs, exp_pat(seq[i], 1'b1, 1'b0));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq(input logic z);
        int seq[3] = '{T_FETCH, T_DECODE, T_BRANCH};
        ifc.op = 6'b000100; ifc.mem_ready = 1'b1; ifc.zero = z;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_pat(seq[i], 1'b1, z)) begin
                errors++;
                $display("FAIL beq_z%0b_cycle%0d: got %h expected %h", z, i, obs, exp_pat(seq[i], 1'b1, z));
            end
            @(posedge clk); #1;
        end
        ifc.zero = 1'b0;
    endtask

    task automatic test_sw_stall();
        int   seq[7] = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMWRITE, T_MEMWRITE, T_MEMWRITE, T_MEMWRITE};
        logic mr[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        ifc.op = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            ifc.mem_ready = mr[i];
            @(negedge clk);
            checks++;
            if (obs !== exp_pat(seq[i], mr[i], 1'b0)) begin
                errors++;
                $display("FAIL sw_cycle%0d: got %h expected %h", i, obs, exp_pat(seq[i], mr[i], 1'b0));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (obs !== exp_pat(T_FETCH, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL sw_refetch: got %h expected %h", obs, exp_pat(T_FETCH, 1'b1, 1'b0));
        end
        @(posedge clk); #1;
        // That FETCH completed; continue with DECODE of a j to land back in FETCH.
        ifc.op = 6'b000010;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs !== exp_pat(T_JUMP, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL sw_then_jump: got %h expected %h", obs, exp_pat(T_JUMP, 1'b1, 1'b0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_addi_jump();
        int seq[7] = '{T_FETCH, T_DECODE, T_ADDIEX, T_ADDIWB, T_FETCH, T_DECODE, T_JUMP};
        ifc.mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ifc.op = (i < 4) ? 6'b001000 : 6'b000010;
            @(negedge clk);
            checks++;
            if (obs !== exp_pat(seq[i], 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL addi_j_cycle%0d: got %h expected %h", i, obs, exp_pat(seq[i], 1'b1, 1'b0));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        int seq[3] = '{T_FETCH, T_DEC_ILL, T_FETCH};
        ifc.op = 6'b111111; ifc.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_pat(seq[i], 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL illegal_cycle%0d: got %h expected %h", i, obs, exp_pat(seq[i], 1'b1, 1'b0));
            end
            @(posedge clk); #1;
        end
        // Leave the re-entered FETCH consumed by the loop above; next task starts in DECODE otherwise.
    endtask

    task automatic test_mid_reset();
        // Entry here is DECODE of the 0x3f instruction's follow-up fetch; use lw from scratch.
        ifc.op = 6'b100011; ifc.mem_ready = 1'b1;
        repeat (2) begin @(negedge clk); @(posedge clk); #1; end
        ifc.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== exp_pat(T_MEMREAD, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL midrst_memread: got %h expected %h", obs, exp_pat(T_MEMREAD, 1'b0, 1'b0));
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 17'h0) begin
            errors++; $display("FAIL midrst_async: got %h expected %h", obs, 17'h0);
        end
        ifc.mem_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== 17'h0) begin
            errors++; $display("FAIL midrst_hold: got %h expected %h", obs, 17'h0);
        end
        rst_n = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs !== exp_pat(T_FETCH, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL midrst_refetch: got %h expected %h", obs, exp_pat(T_FETCH, 1'b1, 1'b0));
        end
    endtask

    task automatic test_watchdog();
        ifc_wd.op = 6'b000000; ifc_wd.zero = 1'b0; ifc_wd.mem_ready = 1'b0;
        @(posedge clk); #1;
        rst_wd_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs_wd !== exp_pat(T_FETCH, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL wd_wait%0d: got %h expected %h", i, obs_wd, exp_pat(T_FETCH, 1'b0, 1'b0));
            end
            @(posedge clk); #1;
        end
        ifc_wd.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs_wd !== exp_pat(T_HALT, 1'b1, 1'b0)) begin
                errors++;
                $display("FAIL wd_halt%0d: got %h expected %h", i, obs_wd, exp_pat(T_HALT, 1'b1, 1'b0));
            end
            @(posedge clk); #1;
        end
        rst_wd_n = 1'b0;
        ifc_wd.mem_ready = 1'b0;
        #1;
        checks++;
        if (obs_wd !== 17'h0) begin
            errors++; $display("FAIL wd_reset_clear: got %h expected %h", obs_wd, 17'h0);
        end
        @(posedge clk); #1;
        rst_wd_n = 1'b1;
        @(posedge clk); #1;
        // mem_ready arriving in the very cycle the count reaches the limit must win.
        for (int i = 0; i < 5; i++) begin
            ifc_wd.mem_ready = (i == 4);
            @(negedge clk);
            checks++;
            if (obs_wd !== exp_pat(T_FETCH, (i == 4), 1'b0)) begin
                errors++;
                $display("FAIL wd_edge%0d: got %h expected %h", i, obs_wd, exp_pat(T_FETCH, (i == 4), 1'b0));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (obs_wd !== exp_pat(T_DECODE, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL wd_edge_decode: got %h expected %h", obs_wd, exp_pat(T_DECODE, 1'b1, 1'b0));
        end
    endtask

    initial begin
        rst_wd_n = 1'b0;
        ifc_wd.op = 6'b0; ifc_wd.zero = 1'b0; ifc_wd.mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_rtype();
        test_beq(1'b1);
        test_beq(1'b0);
        test_sw_stall();
        test_addi_jump();
        test_illegal();
        test_mid_reset();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
